fare_account_server: RTL and testbench

//  Card-account responder for the SkyTrain fare gate.
//  - Gate side: the gate pulses nfc with a card_id. One cycle later this block answers on card_active/fund_enough.
//  - When the gate opens, it pulses reduce_bal. This block then debits FARE from the card last looked up.
//  - Also holds the per-card balance/active tables, which an admin load port writes.

---
 rtl/fare_pkg.sv | 15 +
 rtl/fare_balance_store.sv | 62 ++++++
 rtl/fare_account_server.sv | 150 +++++++++++++++
 tb/tb_fare_account_server.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fare_pkg.sv
// rtl/fare_pkg.sv - shared state encoding and default constants for the fare account server
package fare_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESPOND = 2'd1,
        DEBIT   = 2'd2
    } fare_state_t;

    localparam int NUM_CARDS_DEF = 8;
    localparam int BAL_W_DEF     = 8;
    localparam int FARE_DEF      = 25;
    localparam int TIMEOUT_DEF   = 16;

endpackage

// File: rtl/fare_balance_store.sv
// rtl/fare_balance_store.sv - per-card balance/active table with debit bypass and load-over-debit priority
module fare_balance_store
    import fare_pkg::*;
#(
    parameter int NUM_CARDS = NUM_CARDS_DEF,
    parameter int ID_W      = $clog2(NUM_CARDS_DEF),
    parameter int BAL_W     = BAL_W_DEF,
    parameter int FARE      = FARE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ID_W-1:0]  i_rd_id,
    output logic [BAL_W-1:0] o_rd_bal,
    output logic             o_rd_active,
    input  logic             i_dbt_en,
    input  logic [ID_W-1:0]  i_dbt_id,
    input  logic             i_ld_en,
    input  logic [ID_W-1:0]  i_ld_id,
    input  logic [BAL_W-1:0] i_ld_amt,
    input  logic             i_ld_active
);

    localparam logic [BAL_W-1:0] FARE_V = BAL_W'(FARE);

    logic [BAL_W-1:0]     r_bal [NUM_CARDS];
    logic [NUM_CARDS-1:0] r_active;
    logic [BAL_W-1:0]     w_dbt_bal;

    // Saturating debit of the card being charged this cycle (never wraps below zero)
    always_comb begin
        w_dbt_bal = (r_bal[i_dbt_id] >= FARE_V) ? (r_bal[i_dbt_id] - FARE_V) : '0;
    end

    // Lookup port: a lookup of the card being debited this cycle sees the post-debit balance
    always_comb begin
        o_rd_bal    = r_bal[i_rd_id];
        o_rd_active = r_active[i_rd_id];
        if (i_dbt_en && (i_rd_id == i_dbt_id)) begin
            o_rd_bal = w_dbt_bal;
        end
    end

    // Table update: an admin load overwrites and hides a debit to the same card
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                r_bal[i] <= '0;
            end
            r_active <= '0;
        end else begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                if (i_ld_en && (i_ld_id == ID_W'(i))) begin
                    r_bal[i]    <= i_ld_amt;
                    r_active[i] <= i_ld_active;
                end else if (i_dbt_en && (i_dbt_id == ID_W'(i))) begin
                    r_bal[i] <= w_dbt_bal;
                end
            end
        end
    end

endmodule

// File: rtl/fare_account_server.sv
// rtl/fare_account_server.sv - gate-facing card lookup/debit FSM with response timeout
module fare_account_server
    import fare_pkg::*;
#(
    parameter int NUM_CARDS = NUM_CARDS_DEF,
    parameter int ID_W      = $clog2(NUM_CARDS_DEF),
    parameter int BAL_W     = BAL_W_DEF,
    parameter int FARE      = FARE_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_nfc,
    input  logic [ID_W-1:0]  i_card_id,
    input  logic             i_maintenance,
    input  logic             i_reduce_bal,
    output logic             o_card_active,
    output logic             o_fund_enough,
    output logic             o_resp_valid,
    input  logic             i_load_en,
    input  logic [ID_W-1:0]  i_load_id,
    input  logic [BAL_W-1:0] i_load_amt,
    input  logic             i_load_active,
    output logic             o_debit_err
);

    localparam int               CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BAL_W-1:0] FARE_V = BAL_W'(FARE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fare_state_t      r_state;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_cnt;
    logic             r_card_active;
    logic             r_fund_enough;
    logic             r_resp_valid;
    logic             r_debit_err;

    fare_state_t      w_state_nxt;
    logic [ID_W-1:0]  w_id_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_card_active_nxt;
    logic             w_fund_enough_nxt;
    logic             w_resp_valid_nxt;
    logic             w_debit_err_nxt;
    logic             w_dbt_en;
    logic             w_lookup;
    logic [BAL_W-1:0] w_rd_bal;
    logic             w_rd_active;

    fare_balance_store #(
        .NUM_CARDS (NUM_CARDS),
        .ID_W      (ID_W),
        .BAL_W     (BAL_W),
        .FARE      (FARE)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_id     (i_card_id),
        .o_rd_bal    (w_rd_bal),
        .o_rd_active (w_rd_active),
        .i_dbt_en    (w_dbt_en),
        .i_dbt_id    (r_id),
        .i_ld_en     (i_load_en),
        .i_ld_id     (i_load_id),
        .i_ld_amt    (i_load_amt),
        .i_ld_active (i_load_active)
    );

    // Next-state and response: maintenance clears everything, a fresh tap always restarts the lookup
    always_comb begin
        w_state_nxt       = r_state;
        w_id_nxt          = r_id;
        w_cnt_nxt         = r_cnt;
        w_card_active_nxt = r_card_active;
        w_fund_enough_nxt = r_fund_enough;
        w_resp_valid_nxt  = r_resp_valid;
        w_debit_err_nxt   = (r_state == IDLE) && i_reduce_bal;
        w_dbt_en          = 1'b0;
        w_lookup          = i_nfc && !i_maintenance;

        if (i_maintenance) begin
            w_state_nxt       = IDLE;
            w_card_active_nxt = 1'b0;
            w_fund_enough_nxt = 1'b0;
            w_resp_valid_nxt  = 1'b0;
        end else begin
            case (r_state)
                RESPOND: begin
                    if (i_reduce_bal) begin
                        w_state_nxt = DEBIT;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt       = IDLE;
                        w_card_active_nxt = 1'b0;
                        w_fund_enough_nxt = 1'b0;
                        w_resp_valid_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                DEBIT: begin
                    w_dbt_en          = 1'b1;
                    w_state_nxt       = IDLE;
                    w_card_active_nxt = 1'b0;
                    w_fund_enough_nxt = 1'b0;
                    w_resp_valid_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            if (w_lookup) begin
                w_state_nxt       = RESPOND;
                w_id_nxt          = i_card_id;
                w_cnt_nxt         = '0;
                w_card_active_nxt = w_rd_active;
                w_fund_enough_nxt = (w_rd_bal >= FARE_V);
                w_resp_valid_nxt  = 1'b1;
            end
        end
    end

    // State, latched card, timeout counter and registered gate outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_id          <= '0;
            r_cnt         <= '0;
            r_card_active <= 1'b0;
            r_fund_enough <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_debit_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_id          <= w_id_nxt;
            r_cnt         <= w_cnt_nxt;
            r_card_active <= w_card_active_nxt;
            r_fund_enough <= w_fund_enough_nxt;
            r_resp_valid  <= w_resp_valid_nxt;
            r_debit_err   <= w_debit_err_nxt;
        end
    end

    assign o_card_active = r_card_active;
    assign o_fund_enough = r_fund_enough;
    assign o_resp_valid  = r_resp_valid;
    assign o_debit_err   = r_debit_err;

endmodule

// File: tb/tb_fare_account_server.sv
// tb/tb_fare_account_server.sv - self-checking bench for fare_account_server against a transaction-level model
module tb_fare_account_server;
    import fare_pkg::*;

    localparam int NC   = 8;
    localparam int IDW  = 3;
    localparam int BW   = 8;
    localparam int FARE = 25;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_nfc = 1'b0;
    logic [IDW-1:0] i_card_id = '0;
    logic          i_maintenance = 1'b0;
    logic          i_reduce_bal = 1'b0;
    logic          o_card_active;
    logic          o_fund_enough;
    logic          o_resp_valid;
    logic          i_load_en = 1'b0;
    logic [IDW-1:0] i_load_id = '0;
    logic [BW-1:0] i_load_amt = '0;
    logic          i_load_active = 1'b0;
    logic          o_debit_err;

    fare_account_server #(
        .NUM_CARDS (NC),
        .ID_W      (IDW),
        .BAL_W     (BW),
        .FARE      (FARE),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_nfc         (i_nfc),
        .i_card_id     (i_card_id),
        .i_maintenance (i_maintenance),
        .i_reduce_bal  (i_reduce_bal),
        .o_card_active (o_card_active),
        .o_fund_enough (o_fund_enough),
        .o_resp_valid  (o_resp_valid),
        .i_load_en     (i_load_en),
        .i_load_id     (i_load_id),
        .i_load_amt    (i_load_amt),
        .i_load_active (i_load_active),
        .o_debit_err   (o_debit_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model: account tables plus one outstanding transaction (waiting for a debit, or debiting now)
    int m_bal [NC];
    bit m_act [NC];
    bit m_wait;
    bit m_debit;
    int m_id;
    int m_age;
    bit e_valid, e_act, e_fund, e_err;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_bal[i] = 0;
            m_act[i] = 1'b0;
        end
        m_wait = 0; m_debit = 0; m_id = 0; m_age = 0;
        e_valid = 0; e_act = 0; e_fund = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit idle, do_debit;
        int old_id, dbal, lbal, cid;
        idle     = !m_wait && !m_debit;
        old_id   = m_id;
        do_debit = m_debit && !i_maintenance;
        dbal     = (m_bal[old_id] >= FARE) ? m_bal[old_id] - FARE : 0;
        cid      = int'(i_card_id);
        lbal     = (do_debit && cid == old_id) ? dbal : m_bal[cid];
        e_err    = idle && i_reduce_bal;
        if (i_maintenance) begin
            m_wait = 0; m_debit = 0;
            e_valid = 0; e_act = 0; e_fund = 0;
        end else if (i_nfc) begin
            m_wait = 1; m_debit = 0; m_id = cid; m_age = 0;
            e_valid = 1; e_act = m_act[cid]; e_fund = (lbal >= FARE);
        end else if (m_wait && i_reduce_bal) begin
            m_wait = 0; m_debit = 1;
        end else if (m_wait) begin
            if (m_age == TO - 1) begin
                m_wait = 0; e_valid = 0; e_act = 0; e_fund = 0;
            end else begin
                m_age++;
            end
        end else if (m_debit) begin
            m_debit = 0; e_valid = 0; e_act = 0; e_fund = 0;
        end
        if (do_debit) m_bal[old_id] = dbal;
        if (i_load_en) begin
            m_bal[int'(i_load_id)] = int'(i_load_amt);
            m_act[int'(i_load_id)] = i_load_active;
        end
    endtask

    task automatic tick(input bit nfc, input int id, input bit maint, input bit red,
                        input bit ld, input int lid, input int lamt, input bit lact);
        i_nfc         = nfc;
        i_card_id     = IDW'(id);
        i_maintenance = maint;
        i_reduce_bal  = red;
        i_load_en     = ld;
        i_load_id     = IDW'(lid);
        i_load_amt    = BW'(lamt);
        i_load_active = lact;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Every-cycle comparison of outputs and account balances against the model
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("resp_valid", int'(o_resp_valid), int'(e_valid));
                chk("card_active", int'(o_card_active), int'(e_act));
                chk("fund_enough", int'(o_fund_enough), int'(e_fund));
                chk("debit_err", int'(o_debit_err), int'(e_err));
                for (int i = 0; i < NC; i++) begin
                    chk($sformatf("bal%0d", i), int'(dut.u_store.r_bal[i]), m_bal[i]);
                end
            end
        end
    end

    initial begin
        int r, amt;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", int'(o_resp_valid), 0);
        chk("reset_err", int'(o_debit_err), 0);
        rst_n = 1'b1;
        check_en = 1'b1;

        // 1: normal lookup and debit
        tick(0, 0, 0, 0, 1, 3, 100, 1);
        tick(1, 3, 0, 0, 0, 0, 0, 0);
        chk("t1_valid", int'(o_resp_valid), 1);
        chk("t1_active", int'(o_card_active), 1);
        chk("t1_fund", int'(o_fund_enough), 1);
        tick(0, 0, 0, 1, 0, 0, 0, 0);
        idle_n(1);
        chk("t1_bal3", int'(dut.u_store.r_bal[3]), 75);
        chk("t1_model_bal3", m_bal[3], 75);
        chk("t1_cleared", int'(o_resp_valid), 0);

        // 2: inactive card, timeout after 16 cycles
        tick(0, 0, 0, 0, 1, 5, 100, 0);
        tick(1, 5, 0, 0, 0, 0, 0, 0);
        chk("t2_active", int'(o_card_active), 0);
        chk("t2_fund", int'(o_fund_enough), 1);
        idle_n(15);
        chk("t2_still_valid", int'(o_resp_valid), 1);
        idle_n(1);
        chk("t2_timeout", int'(o_resp_valid), 0);
        chk("t2_bal5", int'(dut.u_store.r_bal[5]), 100);

        // 3: forced debit with insufficient funds saturates at 0
        tick(0, 0, 0, 0, 1, 2, 20, 1);
        tick(1, 2, 0, 0, 0, 0, 0, 0);
        chk("t3_fund", int'(o_fund_enough), 0);
        tick(0, 0, 0, 1, 0, 0, 0, 0);
        idle_n(1);
        chk("t3_bal2", int'(dut.u_store.r_bal[2]), 0);

        // 4: maintenance ignores taps; stray reduce_bal flags an error
        tick(0, 0, 1, 0, 0, 0, 0, 0);
        tick(1, 3, 1, 0, 0, 0, 0, 0);
        chk("t4_valid", int'(o_resp_valid), 0);
        tick(0, 0, 0, 1, 0, 0, 0, 0);
        chk("t4_err", int'(o_debit_err), 1);
        idle_n(1);
        chk("t4_err_pulse", int'(o_debit_err), 0);
        chk("t4_bal3", int'(dut.u_store.r_bal[3]), 75);

        // 5: load beats debit on the same card; stale outputs while responding; debit bypass
        tick(1, 3, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 3, 200, 1);
        chk("t5_bal3", int'(dut.u_store.r_bal[3]), 200);
        tick(1, 3, 0, 0, 0, 0, 0, 0);
        chk("t5_fund", int'(o_fund_enough), 1);
        tick(0, 0, 0, 0, 1, 3, 40, 1);
        chk("t5_stale_fund", int'(o_fund_enough), 1);
        tick(0, 0, 0, 1, 0, 0, 0, 0);
        tick(1, 3, 0, 0, 0, 0, 0, 0);
        chk("t5_bypass_fund", int'(o_fund_enough), 0);
        chk("t5_bypass_valid", int'(o_resp_valid), 1);
        chk("t5_bal3_debited", int'(dut.u_store.r_bal[3]), 15);
        idle_n(17);

        // 6: asynchronous reset mid-transaction
        tick(0, 0, 0, 0, 1, 3, 100, 1);
        tick(1, 3, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_valid", int'(o_resp_valid), 0);
        chk("t6_active", int'(o_card_active), 0);
        chk("t6_bal3", int'(dut.u_store.r_bal[3]), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(1, 3, 0, 0, 0, 0, 0, 0);
        chk("t6_post_active", int'(o_card_active), 0);
        chk("t6_post_fund", int'(o_fund_enough), 0);
        idle_n(17);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: amt = 0;
                1: amt = FARE - 1;
                2: amt = FARE;
                3: amt = FARE + 1;
                4: amt = 255;
                default: amt = $urandom_range(0, 255);
            endcase
            tick($urandom_range(0, 4) == 0, $urandom_range(0, NC - 1),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, NC - 1),
                 amt, $urandom_range(0, 3) != 0);
        end
        idle_n(2);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
